// File: rtl/move_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : move_sched_pkg
// Brief    : Shared types, constants and helpers for move_cmd_scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package move_sched_pkg;

    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        SETTLE = 2'd2
    } sched_state_t;

    typedef enum logic {
        GRP_T = 1'b0,
        GRP_R = 1'b1
    } grp_t;

    typedef enum logic [2:0] {
        CMD_NONE  = 3'd0,
        CMD_FWD   = 3'd1,
        CMD_BWD   = 3'd2,
        CMD_LEFT  = 3'd3,
        CMD_RIGHT = 3'd4
    } cmd_t;

    // Direction 0 is the first button of a group (fwd / left), 1 the second.
    function automatic cmd_t grp_dir_to_cmd(input grp_t grp, input logic dir);
        cmd_t cmd;
        if (grp == GRP_T) begin
            cmd = dir ? CMD_BWD : CMD_FWD;
        end else begin
            cmd = dir ? CMD_RIGHT : CMD_LEFT;
        end
        return cmd;
    endfunction

endpackage
`default_nettype wire

// File: rtl/move_cmd_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : move_cmd_scheduler_if
// Brief    : Button/frame inputs and command strobe outputs of the scheduler.
// Revision : 1.0 - initial release
// ============================================================================
interface move_cmd_scheduler_if;
    import move_sched_pkg::*;

    logic             btn_fwd;
    logic             btn_bwd;
    logic             btn_left;
    logic             btn_right;
    logic             frame_start;

    logic             fwd_pulse;
    logic             bwd_pulse;
    logic             leftRot_pulse;
    logic             rightRot_pulse;
    logic             is_pulse;
    logic             pose_stable;
    logic [CNT_W-1:0] cmd_count;

    modport master (
        output btn_fwd, btn_bwd, btn_left, btn_right, frame_start,
        input  fwd_pulse, bwd_pulse, leftRot_pulse, rightRot_pulse,
        input  is_pulse, pose_stable, cmd_count
    );

    modport slave (
        input  btn_fwd, btn_bwd, btn_left, btn_right, frame_start,
        output fwd_pulse, bwd_pulse, leftRot_pulse, rightRot_pulse,
        output is_pulse, pose_stable, cmd_count
    );

endinterface
`default_nettype wire

// File: rtl/press_tracker.sv
`default_nettype none
// ============================================================================
// Module   : press_tracker
// Brief    : Net-request edge detection and auto-repeat for one button group.
//            Auto-repeat counter exists only with MOVE_SCHED_AUTOREPEAT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module press_tracker
    import move_sched_pkg::*;
`ifdef MOVE_SCHED_AUTOREPEAT_EN
#(
    parameter int INITIAL_DELAY = 12,
    parameter int REPEAT_FRAMES = 4
)
`endif
(
    input  wire logic clk_in,
    input  wire logic rst_n_in,
    input  wire logic i_btn_a,
    input  wire logic i_btn_b,
`ifdef MOVE_SCHED_AUTOREPEAT_EN
    input  wire logic i_frame_start,
`endif
    input  wire logic i_grant,
    output logic      o_eligible,
    output logic      o_dir
);

    logic w_req;
    logic w_dir;
    logic w_new;
    logic r_req_d;
    logic r_dir_d;
    logic r_pending;

    // Both buttons held cancels out, exactly like neither held.
    assign w_req = i_btn_a ^ i_btn_b;
    assign w_dir = i_btn_b;
    assign w_new = w_req & (~r_req_d | (w_dir != r_dir_d));
    assign o_dir = w_dir;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_req_d <= 1'b0;
            r_dir_d <= 1'b0;
        end else begin
            r_req_d <= w_req;
            r_dir_d <= w_dir;
        end
    end

`ifdef MOVE_SCHED_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] c_INIT_THR = CNT_W'(INITIAL_DELAY);
    localparam logic [CNT_W-1:0] c_RPT_THR  = CNT_W'(REPEAT_FRAMES);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [CNT_W-1:0] w_thr;
    logic             r_issued;
    logic             r_repeating;
    logic             w_hit;

    assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + c_CNT_ONE;
    assign w_thr     = r_repeating ? c_RPT_THR : c_INIT_THR;
    // Look ahead at the frame that reaches the threshold so it can issue at once.
    assign w_hit      = ~r_pending & i_frame_start & (w_cnt_inc == w_thr);
    assign o_eligible = w_req & (r_pending | w_hit);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_pending   <= 1'b0;
            r_cnt       <= '0;
            r_issued    <= 1'b0;
            r_repeating <= 1'b0;
        end else if (!w_req) begin
            r_pending   <= 1'b0;
            r_cnt       <= '0;
            r_issued    <= 1'b0;
            r_repeating <= 1'b0;
        end else if (w_new) begin
            r_pending   <= 1'b1;
            r_cnt       <= '0;
            r_issued    <= 1'b0;
            r_repeating <= 1'b0;
        end else if (i_grant) begin
            r_pending   <= 1'b0;
            r_cnt       <= '0;
            r_issued    <= 1'b1;
            r_repeating <= r_issued;
        end else if (i_frame_start) begin
            r_cnt <= w_cnt_inc;
            if (w_hit) begin
                r_pending <= 1'b1;
            end
        end
    end
`else
    assign o_eligible = w_req & r_pending;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_pending <= 1'b0;
        end else if (!w_req) begin
            r_pending <= 1'b0;
        end else if (w_new) begin
            r_pending <= 1'b1;
        end else if (i_grant) begin
            r_pending <= 1'b0;
        end
    end
`endif

endmodule
`default_nettype wire

// File: rtl/move_cmd_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : move_cmd_scheduler
// Brief    : Frame-aligned movement command scheduler with T/R arbitration and
//            optional auto-repeat (MOVE_SCHED_AUTOREPEAT_EN).
// Revision : 1.0 - initial release
// ============================================================================
module move_cmd_scheduler
    import move_sched_pkg::*;
#(
    parameter int INITIAL_DELAY = 12,
    parameter int REPEAT_FRAMES = 4,
    parameter int SETTLE_CYCLES = 2
) (
    input  wire logic           clk_in,
    input  wire logic           rst_n_in,
    move_cmd_scheduler_if.slave bus
);

    localparam logic [1:0]       c_ST_IDLE     = IDLE;
    localparam logic [1:0]       c_ST_ISSUE    = ISSUE;
    localparam logic [1:0]       c_ST_SETTLE   = SETTLE;
    localparam logic [3:0]       c_SETTLE_LAST = 4'(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] c_CNT_ONE     = CNT_W'(1);

    if (SETTLE_CYCLES < 2 || SETTLE_CYCLES > 15 ||
        INITIAL_DELAY < 1 || INITIAL_DELAY > 255 ||
        REPEAT_FRAMES < 1 || REPEAT_FRAMES > 255) begin : g_cfg_check
        $error("move_cmd_scheduler: parameter out of range");
    end

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [3:0]       r_settle_cnt;
    grp_t             r_last_grp;
    grp_t             r_grant_grp;
    grp_t             w_win_grp;
    logic             w_elig_t;
    logic             w_elig_r;
    logic             w_dir_t;
    logic             w_dir_r;
    logic             w_grant_t;
    logic             w_grant_r;
    logic             w_issue;
    cmd_t             w_cmd;
    logic             r_fwd;
    logic             r_bwd;
    logic             r_left;
    logic             r_right;
    logic             r_is_pulse;
    logic             r_pose_stable;
    logic [CNT_W-1:0] r_cmd_count;

    assign w_grant_t = (r_state == c_ST_ISSUE) & (r_grant_grp == GRP_T);
    assign w_grant_r = (r_state == c_ST_ISSUE) & (r_grant_grp == GRP_R);

    press_tracker
`ifdef MOVE_SCHED_AUTOREPEAT_EN
        #(.INITIAL_DELAY(INITIAL_DELAY), .REPEAT_FRAMES(REPEAT_FRAMES))
`endif
    u_trk_t (
        .clk_in        (clk_in),
        .rst_n_in      (rst_n_in),
        .i_btn_a       (bus.btn_fwd),
        .i_btn_b       (bus.btn_bwd),
`ifdef MOVE_SCHED_AUTOREPEAT_EN
        .i_frame_start (bus.frame_start),
`endif
        .i_grant       (w_grant_t),
        .o_eligible    (w_elig_t),
        .o_dir         (w_dir_t)
    );

    press_tracker
`ifdef MOVE_SCHED_AUTOREPEAT_EN
        #(.INITIAL_DELAY(INITIAL_DELAY), .REPEAT_FRAMES(REPEAT_FRAMES))
`endif
    u_trk_r (
        .clk_in        (clk_in),
        .rst_n_in      (rst_n_in),
        .i_btn_a       (bus.btn_left),
        .i_btn_b       (bus.btn_right),
`ifdef MOVE_SCHED_AUTOREPEAT_EN
        .i_frame_start (bus.frame_start),
`endif
        .i_grant       (w_grant_r),
        .o_eligible    (w_elig_r),
        .o_dir         (w_dir_r)
    );

    // On a tie the group that did not win last time goes first.
    always_comb begin
        w_win_grp = GRP_T;
        if (w_elig_t && w_elig_r) begin
            w_win_grp = (r_last_grp == GRP_R) ? GRP_T : GRP_R;
        end else if (w_elig_r) begin
            w_win_grp = GRP_R;
        end
    end

    assign w_issue = (r_state == c_ST_IDLE) & bus.frame_start & (w_elig_t | w_elig_r);
    assign w_cmd   = w_issue ? grp_dir_to_cmd(w_win_grp, (w_win_grp == GRP_T) ? w_dir_t : w_dir_r)
                             : CMD_NONE;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:   if (w_issue) w_state_nxt = c_ST_ISSUE;
            c_ST_ISSUE:  w_state_nxt = c_ST_SETTLE;
            c_ST_SETTLE: if (r_settle_cnt == c_SETTLE_LAST) w_state_nxt = c_ST_IDLE;
            default:     w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state      <= c_ST_IDLE;
            r_settle_cnt <= '0;
            r_last_grp   <= GRP_R;
            r_grant_grp  <= GRP_T;
            r_cmd_count  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == c_ST_ISSUE) begin
                r_settle_cnt <= 4'd1;
            end else if (r_state == c_ST_SETTLE) begin
                r_settle_cnt <= r_settle_cnt + 4'd1;
            end
            if (w_issue) begin
                r_grant_grp <= w_win_grp;
                r_last_grp  <= w_win_grp;
                r_cmd_count <= r_cmd_count + c_CNT_ONE;
            end
        end
    end

    // Strobes decided in IDLE are registered, so later button changes cannot alter them.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_fwd         <= 1'b0;
            r_bwd         <= 1'b0;
            r_left        <= 1'b0;
            r_right       <= 1'b0;
            r_is_pulse    <= 1'b0;
            r_pose_stable <= 1'b1;
        end else begin
            r_fwd         <= (w_cmd == CMD_FWD);
            r_bwd         <= (w_cmd == CMD_BWD);
            r_left        <= (w_cmd == CMD_LEFT);
            r_right       <= (w_cmd == CMD_RIGHT);
            r_is_pulse    <= w_issue;
            r_pose_stable <= (w_state_nxt == c_ST_IDLE);
        end
    end

    assign bus.fwd_pulse      = r_fwd;
    assign bus.bwd_pulse      = r_bwd;
    assign bus.leftRot_pulse  = r_left;
    assign bus.rightRot_pulse = r_right;
    assign bus.is_pulse       = r_is_pulse;
    assign bus.pose_stable    = r_pose_stable;
    assign bus.cmd_count      = r_cmd_count;

endmodule
`default_nettype wire

// File: tb/tb_move_cmd_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_move_cmd_scheduler
// Brief    : Directed scoreboard bench for move_cmd_scheduler.
// Revision : 1.0 - initial release
// ============================================================================
module tb_move_cmd_scheduler;
    import move_sched_pkg::*;

    localparam int TB_INIT   = 12;
    localparam int TB_RPT    = 4;
    localparam int TB_SETTLE = 2;
    localparam int GAP       = 8;

    typedef struct packed {
        cmd_t       cmd;
        logic [7:0] count;
    } exp_t;

    logic       clk_in = 1'b0;
    logic       rst_n_in;
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] exp_count;
    exp_t       sb_q[$];

    always #5 clk_in = ~clk_in;

    move_cmd_scheduler_if bus();

    move_cmd_scheduler #(
        .INITIAL_DELAY (TB_INIT),
        .REPEAT_FRAMES (TB_RPT),
        .SETTLE_CYCLES (TB_SETTLE)
    ) dut (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .bus      (bus)
    );

    function automatic logic [4:0] obs_vec();
        return {bus.fwd_pulse, bus.bwd_pulse, bus.leftRot_pulse, bus.rightRot_pulse, bus.is_pulse};
    endfunction

    function automatic logic [4:0] strobe_vec(input cmd_t c);
        return {c == CMD_FWD, c == CMD_BWD, c == CMD_LEFT, c == CMD_RIGHT, c != CMD_NONE};
    endfunction

    function automatic bit repeat_issue(input int k);
`ifdef MOVE_SCHED_AUTOREPEAT_EN
        return (k == 1) || (k >= 1 + TB_INIT && ((k - 1 - TB_INIT) % TB_RPT) == 0);
`else
        return (k == 1);
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_output(input string tag);
        exp_t e;
        n_checks++;
        assert (sb_q.size() > 0) else begin
            n_fail++;
            $error("FAIL %s_sb: observed empty queue expected entry", tag);
        end
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check({tag, "_strobes"}, obs_vec(), strobe_vec(e.cmd));
            check({tag, "_count"}, bus.cmd_count, e.count);
            check({tag, "_pose"}, bus.pose_stable, e.cmd == CMD_NONE);
        end
    endtask

    // Called on a falling edge; pulses frame_start for the next rising edge.
    task automatic do_frame(input string tag, input cmd_t exp_cmd, input int gap);
        exp_t e;
        if (exp_cmd != CMD_NONE) exp_count++;
        e.cmd   = exp_cmd;
        e.count = exp_count;
        sb_q.push_back(e);
        bus.frame_start = 1'b1;
        @(negedge clk_in);
        bus.frame_start = 1'b0;
        check_output(tag);
        for (int i = 0; i < gap; i++) begin
            @(negedge clk_in);
            check({tag, "_gap_strobes"}, obs_vec(), 5'b0);
            check({tag, "_gap_pose"}, bus.pose_stable,
                  (exp_cmd != CMD_NONE && i < TB_SETTLE) ? 1'b0 : 1'b1);
        end
    endtask

    task automatic release_buttons();
        bus.btn_fwd     = 1'b0;
        bus.btn_bwd     = 1'b0;
        bus.btn_left    = 1'b0;
        bus.btn_right   = 1'b0;
        bus.frame_start = 1'b0;
    endtask

    task automatic apply_reset();
        release_buttons();
        rst_n_in = 1'b0;
        repeat (3) @(negedge clk_in);
        rst_n_in = 1'b1;
        sb_q.delete();
        exp_count = 8'd0;
        @(negedge clk_in);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        release_buttons();
        rst_n_in  = 1'b0;
        exp_count = 8'd0;
        repeat (2) @(negedge clk_in);
        check("reset_strobes", obs_vec(), 5'b0);
        check("reset_pose", bus.pose_stable, 1'b1);
        check("reset_count", bus.cmd_count, 8'd0);
        rst_n_in = 1'b1;
        @(negedge clk_in);

        // Single press, frame near cycle 100
        bus.btn_fwd = 1'b1;
        repeat (96) @(negedge clk_in);
        do_frame("single", CMD_FWD, GAP);
        check("single_total", bus.cmd_count, 8'd1);

        // Opposing buttons cancel, releasing one gives a fresh request
        apply_reset();
        bus.btn_fwd = 1'b1;
        bus.btn_bwd = 1'b1;
        @(negedge clk_in);
        for (int k = 0; k < 5; k++) do_frame($sformatf("opp_both%0d", k), CMD_NONE, GAP);
        bus.btn_bwd = 1'b0;
        @(negedge clk_in);
        do_frame("opp_release", CMD_FWD, GAP);

        // Tie: first goes to T after reset, R waits one frame
        apply_reset();
        bus.btn_fwd  = 1'b1;
        bus.btn_left = 1'b1;
        @(negedge clk_in);
        do_frame("tie_f1", CMD_FWD, GAP);
        do_frame("tie_f2", CMD_LEFT, GAP);
        do_frame("tie_f3", CMD_NONE, GAP);
        do_frame("tie_f4", CMD_NONE, GAP);

        // Held rotate button over 30 frames
        apply_reset();
        bus.btn_right = 1'b1;
        @(negedge clk_in);
        for (int k = 1; k <= 30; k++) begin
            do_frame($sformatf("hold_f%0d", k), repeat_issue(k) ? CMD_RIGHT : CMD_NONE, GAP);
        end
`ifdef MOVE_SCHED_AUTOREPEAT_EN
        check("hold_total", bus.cmd_count, 8'd6);
`else
        check("hold_total", bus.cmd_count, 8'd1);
`endif

        // Frame pulse during SETTLE must not issue the newly pressed group
        apply_reset();
        bus.btn_fwd = 1'b1;
        @(negedge clk_in);
        do_frame("settle_issue", CMD_FWD, 0);
        bus.btn_left = 1'b1;
        @(negedge clk_in);
        check("settle_n2_strobes", obs_vec(), 5'b0);
        bus.frame_start = 1'b1;
        @(negedge clk_in);
        bus.frame_start = 1'b0;
        check("settle_fs_strobes", obs_vec(), 5'b0);
        check("settle_fs_count", bus.cmd_count, 8'd1);
        @(negedge clk_in);
        check("settle_after_strobes", obs_vec(), 5'b0);
        repeat (GAP) @(negedge clk_in);
        do_frame("settle_next", CMD_LEFT, GAP);

        // Asynchronous reset in the middle of SETTLE
        apply_reset();
        bus.btn_fwd = 1'b1;
        @(negedge clk_in);
        do_frame("arst_issue", CMD_FWD, 1);
        #2 rst_n_in = 1'b0;
        #1;
        check("arst_strobes", obs_vec(), 5'b0);
        check("arst_pose", bus.pose_stable, 1'b1);
        check("arst_count", bus.cmd_count, 8'd0);
        @(negedge clk_in);
        rst_n_in = 1'b1;
        sb_q.delete();
        exp_count = 8'd0;
        @(negedge clk_in);
        do_frame("arst_reissue", CMD_FWD, GAP);

        check("sb_empty", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
